// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the core execute stage (port 0) and the aux unit (port 1).
// Build option ALU_ARB_FIXED_PRI_EN: port 0 always wins ties instead of round-robin.
module alu_arbiter #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_start,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero,
    output logic         busy
);
    // state | meaning
    // IDLE  | no op in flight; grant computed combinationally
    // BUSY  | ALU inputs held, down-counting to the alu_out sample cycle
    // RESP  | result held for the owner until it takes it
    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    stateT      state;
    stateT      stateNext;
    logic [1:0] grant;
    logic       accept;
    logic       acceptPort;
    logic       owner;
    logic [3:0] count;
`ifndef ALU_ARB_FIXED_PRI_EN
    logic       lastGrant;
`endif

    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:
`ifdef ALU_ARB_FIXED_PRI_EN
                    grant = 2'b01;
`else
                    grant = lastGrant ? 2'b01 : 2'b10;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready  = grant;
    assign accept     = |(req_valid & grant);
    assign acceptPort = grant[1];

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = BUSY;
            BUSY:    if (count == 4'd0) stateNext = RESP;
            RESP:    if (rsp_ready[owner]) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);

    // ALU inputs only load on accept, so they hold their last values through IDLE and RESP
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            count     <= 4'd0;
            alu_start <= 1'b0;
            alu_op    <= 4'b0000;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
            lastGrant <= 1'b1;
`endif
        end else begin
            state     <= stateNext;
            alu_start <= 1'b0;
            if (accept) begin
                owner     <= acceptPort;
                count     <= CNT_INIT;
                alu_start <= 1'b1;
                alu_op    <= acceptPort ? req_op1 : req_op0;
                alu_a     <= acceptPort ? req_a1  : req_a0;
                alu_b     <= acceptPort ? req_b1  : req_b0;
`ifndef ALU_ARB_FIXED_PRI_EN
                lastGrant <= acceptPort;
`endif
            end else if (state == BUSY) begin
                if (count == 4'd0) begin
                    rsp_data <= alu_out;
                    rsp_zero <= alu_zero;
                end else begin
                    count <= count - 4'd1;
                end
            end
        end
    end
endmodule
